mem_rsp: RTL and testbench
==========================

# mem_rsp

Line-granular memory responder: the answering end of the table-walk memory port driven by the VLB walker. It accepts read requests carrying a walker index and a 64-byte memory cache-line number. It returns the 512-bit line from a preloadable backing store, tagged with the same index, in request order and after a fixed minimum latency. It sits between the walker's `mem_req`/`mem_res` ports and the bench or system memory model.

## Interface
Parameters:
- `IDX_W`, default 2: walker index width, matches `ttw_t`.
- `MCN_W`, default 58: cache-line number width, matches `mcn_t`.
- `AW`, default 8: backing store address bits; the store holds 2^AW lines.
- `DEPTH`, default 4: outstanding request queue depth, power of two, at least 2.
- `LAT`, default 4: minimum request-to-response latency in cycles, at least 2.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: reset, asynchronous and active-low.
- `mem_req_i_valid` in 1: request valid.
- `mem_req_i_ready` out 1: request accepted when both valid and ready are high.
- `mem_req_i_bits_idx` in IDX_W: walker index.
- `mem_req_i_bits_mcn` in MCN_W: line number.
- `mem_res_o_valid` out 1: response valid.
- `mem_res_o_ready` in 1: walker accepts the response.
- `mem_res_o_bits_idx` out IDX_W: echoed index.
- `mem_res_o_bits_data` out 512: line data.
- `ld_i_valid` in 1: backing store write strobe.
- `ld_i_addr` in AW: store line address.
- `ld_i_data` in 512: store line data.
- `busy_o` out 1: queue non-empty or response pending.

## Operation
- Request queue: a FIFO of {idx, mcn, age}.
  - Push on a request handshake.
  - `mem_req_i_ready` = queue not full (gated further by the stall LFSR when configured).
  - A push and a pop in the same cycle are allowed when the queue is full; `ready` stays low while full regardless.
- Age: each entry's counter starts at 0 and saturates at LAT.
- Head eligible: the head entry is eligible when its age ≥ LAT-1.
- Output register: holds {valid, idx, data}.
  - Loads from an eligible head when empty, or in the same cycle its current contents handshake.
  - Data = store[mcn[AW-1:0]].
  - Bits of mcn above AW are ignored, so addresses alias modulo 2^AW.
- Output hold: `mem_res_o_valid`, idx and data stay stable until `mem_res_o_ready`; there is no retraction.
- Ordering: strictly in order; indices are not checked for uniqueness.
- Store write: `ld_i_valid` writes the line at the clock edge.
  - A same-cycle load of the output register reads the pre-write value.
  - The store is not reset.
- `busy_o` = queue non-empty OR output valid.
- Reset values:
  - `mem_req_i_ready` 0 while reset is asserted, 1 from the first cycle after release (stall-gated when configured).
  - `mem_res_o_valid` 0, `mem_res_o_bits_idx` 0, `mem_res_o_bits_data` 0.
  - `busy_o` 0.
  - Queue pointers and ages cleared.
- Reset mid-operation drops all outstanding requests and any pending response; no response is produced for them.

## Timing
- A request accepted at the edge ending cycle T gives `mem_res_o_valid` no earlier than cycle T+LAT.
  - With the queue idle and `mem_res_o_ready` high, it is exactly T+LAT.
- Back-to-back throughput: one response per cycle when requests are issued one per cycle and `mem_res_o_ready` stays high.
- `mem_req_i_ready` depends only on registered state; it has no combinational path from `mem_req_i_valid`.
- `mem_res_o_ready` low freezes the output register.
  - The queue keeps accepting requests until full.
  - Ages keep counting.

## Configuration
- `MEM_RSP_STALL_EN`: a 16-bit Fibonacci LFSR is compiled in.
  - Taps 16,14,13,11; reset seed 16'hACE1; it steps every cycle.
  - `mem_req_i_ready` is additionally forced low whenever lfsr[1:0]==2'b00.
- Without the macro: no LFSR; `ready` = not full.

## Structure
- Package `mem_rsp_pkg` holds:
  - the `ttw_t` and `mcn_t` width constants;
  - the line width 512;
  - the queue entry struct {idx, mcn, age};
  - the LFSR seed and tap constants.
- Sub-module `mem_rsp_fifo`: a generic DEPTH-entry queue with push, pop, full, empty and a head view; ages are updated in the parent.

## Test plan
- Preload line 5 = 512'hA5..A5; request idx=1, mcn=5 in cycle 10 → `mem_res_o_valid` in cycle 14 with idx=1 and data A5..A5 (LAT=4).
- Issue 4 requests idx 0..3 back-to-back with `mem_res_o_ready` low → `mem_req_i_ready` falls after the 4th. Then raise ready → 4 responses on consecutive cycles in order 0,1,2,3, and `ready` rises one cycle after the first pop.
- Request with mcn = 58'h100 | 3 and AW=8 → returns line 3 (aliasing).
- `ld_i` writes line 7 in the same cycle the output loads line 7 → response carries the old data; the next request to line 7 returns the new data.
- Assert `reset` with 3 requests queued and the response held → all outputs are 0 and `busy_o`=0; after release, one fresh request completes in LAT cycles.
- With `MEM_RSP_STALL_EN` and valid held high → `ready` low exactly on cycles where lfsr[1:0]==0, and every accepted request is answered once.

Source files
------------

// File: rtl/mem_rsp_pkg.sv
// Shared widths, queue entry layout and stall-LFSR constants for the memory responder.
package mem_rsp_pkg;

  localparam int TTW_W     = 2;
  localparam int MCN_W_DEF = 58;
  localparam int LINE_W    = 512;
  localparam int AGE_W     = 8;

  typedef logic [TTW_W-1:0]     ttw_t;
  typedef logic [MCN_W_DEF-1:0] mcn_t;

  typedef struct packed {
    ttw_t             idx;
    mcn_t             mcn;
    logic [AGE_W-1:0] age;
  } q_ent_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Generic DEPTH-entry queue with head view; exposes its pointers so the parent can
// keep per-slot side state.
module mem_rsp_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [W-1:0]  o_head,
  output logic [PW-1:0] o_wptr,
  output logic [PW-1:0] o_rptr
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rptr];
  assign o_wptr    = r_wptr;
  assign o_rptr    = r_rptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + (PW+1)'(1);
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_dat;
  end

endmodule

// File: rtl/mem_rsp.sv
// In-order line responder: queued requests answered from a preloadable store after LAT cycles.
// MEM_RSP_STALL_EN compiles in an LFSR that randomly withholds request ready.
module mem_rsp
  import mem_rsp_pkg::*;
#(
  parameter int IDX_W = TTW_W,
  parameter int MCN_W = MCN_W_DEF,
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_req_i_valid,
  output logic              mem_req_i_ready,
  input  logic [IDX_W-1:0]  mem_req_i_bits_idx,
  input  logic [MCN_W-1:0]  mem_req_i_bits_mcn,
  output logic              mem_res_o_valid,
  input  logic              mem_res_o_ready,
  output logic [IDX_W-1:0]  mem_res_o_bits_idx,
  output logic [LINE_W-1:0] mem_res_o_bits_data,
  input  logic              ld_i_valid,
  input  logic [AW-1:0]     ld_i_addr,
  input  logic [LINE_W-1:0] ld_i_data,
  output logic              busy_o
);

  localparam int AGW = $clog2(LAT+1);
  localparam int PW  = $clog2(DEPTH);
  localparam int EW  = IDX_W + AW;
  localparam logic [AGW-1:0] AGE_MAX  = AGW'(LAT);
  localparam logic [AGW-1:0] AGE_ELIG = AGW'(LAT-1);

  logic              w_full, w_empty, w_push, w_pop, w_elig, w_rdy;
  logic [EW-1:0]     w_head;
  logic [PW-1:0]     w_wptr, w_rptr;
  logic              w_unused;
  logic [AGW-1:0]    r_age [DEPTH];
  logic              r_rdy_en;
  logic              r_vld;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_data;
  logic [LINE_W-1:0] r_store [2**AW];

  // Line numbers alias modulo the store size; only the low AW bits are queued.
  assign w_unused = ^mem_req_i_bits_mcn[MCN_W-1:AW];

`ifdef MEM_RSP_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= lfsr_next(r_lfsr);
  end
  assign w_rdy = r_rdy_en & ~w_full & (r_lfsr[1:0] != 2'b00);
`else
  assign w_rdy = r_rdy_en & ~w_full;
`endif

  assign mem_req_i_ready = w_rdy;
  assign w_push = mem_req_i_valid & w_rdy;
  assign w_elig = ~w_empty & (r_age[w_rptr] >= AGE_ELIG);
  assign w_pop  = w_elig & (~r_vld | mem_res_o_ready);

  mem_rsp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_dat   ({mem_req_i_bits_idx, mem_req_i_bits_mcn[AW-1:0]}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_wptr  (w_wptr),
    .o_rptr  (w_rptr)
  );

  // The accept edge counts as the entry's first aged cycle, so it reads 1 when first visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_wptr == PW'(i))) r_age[i] <= AGW'(1);
        else if (r_age[i] != AGE_MAX)     r_age[i] <= r_age[i] + AGW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdy_en <= 1'b0;
      r_vld    <= 1'b0;
      r_idx    <= '0;
      r_data   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_pop) begin
        r_vld  <= 1'b1;
        r_idx  <= w_head[EW-1:AW];
        r_data <= r_store[w_head[AW-1:0]];
      end else if (mem_res_o_ready) begin
        r_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ld_i_valid) r_store[ld_i_addr] <= ld_i_data;
  end

  assign mem_res_o_valid     = r_vld;
  assign mem_res_o_bits_idx  = r_idx;
  assign mem_res_o_bits_data = r_data;
  assign busy_o              = ~w_empty | r_vld;

endmodule

// File: tb/tb_mem_rsp.sv
// Bench for mem_rsp: directed scenarios plus random traffic against a transaction-level model
// (request list with accept cycles, one output slot, shadow store with write-after-read timing).
module tb_mem_rsp;

  localparam int IDX_W = 2;
  localparam int MCN_W = 58;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              mem_req_i_valid = 1'b0;
  logic              mem_req_i_ready;
  logic [IDX_W-1:0]  mem_req_i_bits_idx = '0;
  logic [MCN_W-1:0]  mem_req_i_bits_mcn = '0;
  logic              mem_res_o_valid;
  logic              mem_res_o_ready = 1'b1;
  logic [IDX_W-1:0]  mem_res_o_bits_idx;
  logic [511:0]      mem_res_o_bits_data;
  logic              ld_i_valid = 1'b0;
  logic [AW-1:0]     ld_i_addr = '0;
  logic [511:0]      ld_i_data = '0;
  logic              busy_o;

  mem_rsp #(.IDX_W(IDX_W), .MCN_W(MCN_W), .AW(AW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clock               (clock),
    .reset               (reset),
    .mem_req_i_valid     (mem_req_i_valid),
    .mem_req_i_ready     (mem_req_i_ready),
    .mem_req_i_bits_idx  (mem_req_i_bits_idx),
    .mem_req_i_bits_mcn  (mem_req_i_bits_mcn),
    .mem_res_o_valid     (mem_res_o_valid),
    .mem_res_o_ready     (mem_res_o_ready),
    .mem_res_o_bits_idx  (mem_res_o_bits_idx),
    .mem_res_o_bits_data (mem_res_o_bits_data),
    .ld_i_valid          (ld_i_valid),
    .ld_i_addr           (ld_i_addr),
    .ld_i_data           (ld_i_data),
    .busy_o              (busy_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [AW-1:0]    line;
    int               acc;
  } req_t;

  req_t             q[$];
  logic [511:0]     mstore [256];
  logic             m_vld = 1'b0;
  logic [IDX_W-1:0] m_idx;
  logic [511:0]     m_data;
  logic             rdy_en = 1'b0;
  logic             wr_pend = 1'b0;
  logic [AW-1:0]    wr_addr;
  logic [511:0]     wr_data;
  logic [15:0]      m_lfsr = 16'hACE1;
  int               cyc = 0;

  always @(negedge clock) begin
    logic rdy;
    if (!reset) begin
      chk("rst_req_rdy", mem_req_i_ready, 0);
      chk("rst_res_vld", mem_res_o_valid, 0);
      chk("rst_res_idx", mem_res_o_bits_idx, 0);
      chk("rst_res_data", mem_res_o_bits_data, 0);
      chk("rst_busy", busy_o, 0);
      q.delete();
      m_vld  = 1'b0;
      rdy_en = 1'b0;
      m_lfsr = 16'hACE1;
    end else begin
      if (!m_vld && q.size() > 0 && q[0].acc + LAT <= cyc) begin
        m_vld  = 1'b1;
        m_idx  = q[0].idx;
        m_data = mstore[q[0].line];
        void'(q.pop_front());
      end
      rdy = rdy_en && (q.size() < DEPTH);
`ifdef MEM_RSP_STALL_EN
      rdy = rdy && (m_lfsr[1:0] != 2'b00);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
      chk("req_rdy", mem_req_i_ready, rdy);
      chk("res_vld", mem_res_o_valid, m_vld);
      if (m_vld) begin
        chk("res_idx", mem_res_o_bits_idx, m_idx);
        chk("res_data", mem_res_o_bits_data, m_data);
      end
      chk("busy", busy_o, (q.size() > 0) || m_vld);
      if (mem_req_i_valid && rdy)
        q.push_back('{idx: mem_req_i_bits_idx, line: mem_req_i_bits_mcn[AW-1:0], acc: cyc});
      if (m_vld && mem_res_o_ready) m_vld = 1'b0;
      rdy_en = 1'b1;
    end
    // A store write becomes visible to output loads only after its own edge.
    if (wr_pend) mstore[wr_addr] = wr_data;
    wr_pend = ld_i_valid;
    wr_addr = ld_i_addr;
    wr_data = ld_i_data;
    cyc++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send(input logic [IDX_W-1:0] idx, input logic [MCN_W-1:0] mcn);
    int n = 0;
    mem_req_i_valid    = 1'b1;
    mem_req_i_bits_idx = idx;
    mem_req_i_bits_mcn = mcn;
    @(negedge clock);
    while (!mem_req_i_ready && n < 64) begin
      n++;
      @(negedge clock);
    end
    chk("send_timeout", 32'(n >= 64), 0);
    @(posedge clock);
    #1;
    mem_req_i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    mem_res_o_ready = 1'b1;
    while ((q.size() > 0 || m_vld) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= 300), 0);
  endtask

  task automatic load_line(input logic [AW-1:0] a, input logic [511:0] d);
    ld_i_valid = 1'b1;
    ld_i_addr  = a;
    ld_i_data  = d;
    step();
    ld_i_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();

    for (int a = 0; a < 256; a++) load_line(AW'(a), rnd512());
    load_line(8'd5, {64{8'hA5}});
    step();

    // Single request to the A5 line; timing and content come from the model.
    send(2'd1, 58'd5);
    drain();

    // Four back-to-back with the response side stalled, then release.
    mem_res_o_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(IDX_W'(i), 58'(i + 20));
    repeat (8) step();
    drain();

    // Hold valid high against a stalled response side until the queue fills.
    mem_res_o_ready    = 1'b0;
    mem_req_i_valid    = 1'b1;
    mem_req_i_bits_mcn = 58'd40;
    repeat (12) step();
    mem_req_i_valid = 1'b0;
    drain();

    // Upper line-number bits alias onto the store.
    send(2'd2, 58'h100 | 58'd3);
    drain();

    // Store write on the same edge the output loads line 7.
    send(2'd2, 58'd7);
    step();
    step();
    ld_i_valid = 1'b1;
    ld_i_addr  = 8'd7;
    ld_i_data  = rnd512();
    step();
    ld_i_valid = 1'b0;
    drain();
    send(2'd3, 58'd7);
    drain();

    // Reset while requests are queued and a response is held.
    mem_res_o_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(IDX_W'(i), 58'(i + 60));
    repeat (6) step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    send(2'd0, 58'd9);
    drain();

    // Continuous valid with the response side open.
    mem_req_i_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mem_req_i_bits_idx = IDX_W'($urandom);
      mem_req_i_bits_mcn = {26'($urandom), 32'($urandom)};
      step();
    end
    mem_req_i_valid = 1'b0;
    drain();

    // Random traffic including store writes.
    for (int i = 0; i < 600; i++) begin
      mem_req_i_valid    = ($urandom_range(9) < 6);
      mem_req_i_bits_idx = IDX_W'($urandom);
      mem_req_i_bits_mcn = {26'($urandom), 32'($urandom)};
      mem_res_o_ready    = ($urandom_range(9) < 7);
      ld_i_valid         = ($urandom_range(15) == 0);
      ld_i_addr          = AW'($urandom);
      ld_i_data          = rnd512();
      step();
    end
    mem_req_i_valid = 1'b0;
    ld_i_valid      = 1'b0;
    drain();
    step();
    chk("left_outstanding", q.size(), 0);
    chk("final_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
